xalu_pipe: RTL

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the execute stage, successor to the fixed 32-bit XALU. Accepts one operation at a time from the execute stage, holds `busy` for a configurable latency per class, then commits HI/LO atomically. Supports cancel by interrupt and by pipeline clear without corrupting architectural HI/LO. The hazard unit stalls on `busy`.

---
 rtl/xalu_pipe_if.sv | 30 +++
 rtl/xalu_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xalu_pipe_if.sv
// xalu_pipe_if: execute-stage <-> multiply/divide unit bundle.
// The master side (execute stage) launches operations and mthi/mtlo
// writes. The slave side (xalu_pipe) reports busy/done/dz and drives HI/LO.
interface xalu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             we;
  logic             hilo;
  logic             interrupt;
  logic             clear;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, d1, d2, we, hilo, interrupt, clear,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, d1, d2, we, hilo, interrupt, clear,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/xalu_pipe.sv
// xalu_pipe: multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed when the operation is accepted and held in shadow
// registers; busy is held for MUL_LAT or DIV_LAT cycles, then HI/LO are
// committed together. clear aborts the in-flight op without touching HI/LO.
// Optional feature macro: XALU_MADD_EN enables maddu/madd/msubu/msub
// (ops 100-111); without it those starts are ignored and no accumulator
// adder is built.
module xalu_pipe #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  xalu_pipe_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] res_q;
  logic               div_q;
  logic               dz_pend_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;
  logic               done_q;
  logic               busy_q;
`ifdef XALU_MADD_EN
  logic               acc_q;
  logic               sub_q;
`endif

  // ---------------------------------------------------------------------
  // Operation decode and result datapath
  // ---------------------------------------------------------------------
  logic               sgn;
  logic               is_div;
  logic               op_ok;
  logic               accept;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;
  logic [2*WIDTH-1:0] commit_val;

  assign sgn    = bus.op[0];
  assign is_div = (bus.op[2:1] == 2'b01);

`ifdef XALU_MADD_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~bus.op[2];
`endif

  // A start is taken only from IDLE and only when not suppressed.
  assign accept = (state_q == IDLE) && bus.start && !bus.interrupt &&
                  !bus.clear && op_ok;

  // One multiplier serves both signednesses: the low 2*WIDTH bits of the
  // product of the sign-extended operands is the signed product.
  assign a_ext = {{WIDTH{sgn & bus.d1[WIDTH-1]}}, bus.d1};
  assign b_ext = {{WIDTH{sgn & bus.d2[WIDTH-1]}}, bus.d2};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero and the remainder follows the dividend. MIN/-1 falls out of this
  // naturally as quotient MIN, remainder 0.
  assign a_neg    = sgn & bus.d1[WIDTH-1];
  assign b_neg    = sgn & bus.d2[WIDTH-1];
  assign a_mag    = a_neg ? (~bus.d1 + 1'b1) : bus.d1;
  assign b_mag    = b_neg ? (~bus.d2 + 1'b1) : bus.d2;
  assign div_zero = (bus.d2 == '0);
  assign b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;

  // Final quotient/remainder, including the divide-by-zero convention
  always_comb begin
    quot = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem  = a_neg ? (~r_mag + 1'b1) : r_mag;
    if (div_zero) begin
      quot = '1;
      rem  = bus.d1;
    end
  end

  // Value written to {HI,LO} at commit; accumulation uses HI/LO as they
  // stand at the commit edge.
  always_comb begin
    commit_val = res_q;
`ifdef XALU_MADD_EN
    if (acc_q) begin
      commit_val = sub_q ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Control FSM, shadow registers and architectural HI/LO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      div_q     <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef XALU_MADD_EN
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            cnt_q     <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            res_q     <= is_div ? {rem, quot} : prod;
            div_q     <= is_div;
            dz_pend_q <= is_div & div_zero;
`ifdef XALU_MADD_EN
            acc_q     <= bus.op[2];
            sub_q     <= bus.op[1];
`endif
          end else if (bus.we && !bus.start && !bus.interrupt) begin
            if (bus.hilo) hi_q <= bus.d1;
            else          lo_q <= bus.d1;
          end
        end
        RUN: begin
          if (bus.clear) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            hi_q    <= commit_val[2*WIDTH-1:WIDTH];
            lo_q    <= commit_val[WIDTH-1:0];
            if (div_q) dz_q <= dz_pend_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
